inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_if.sv | 34 +++
 rtl/inst_buffer.sv | 99 +++++++++
 tb/tb_inst_buffer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_if.sv
// Fetch-to-decode instruction buffer interface: upstream fetch group in,
// decode issue group out. Slot 0 is always the oldest instruction.
`ifndef ICACHE_BANK
`define ICACHE_BANK 4
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

interface inst_buffer_if #(
    parameter int IN_W  = `ICACHE_BANK,
    parameter int OUT_W = `FETCH_WIDTH
);
    localparam int NW = (IN_W > 1) ? $clog2(IN_W) : 1;

    logic [IN_W-1:0]        in_en;
    logic [NW-1:0]          in_num;
    logic [IN_W-1:0][31:0]  in_inst;
    logic                   full;
    logic                   dec_stall;
    logic                   flush;
    logic [OUT_W-1:0]       out_en;
    logic [OUT_W-1:0][31:0] out_inst;

    modport master (
        output in_en, in_num, in_inst, dec_stall, flush,
        input  full, out_en, out_inst
    );

    modport slave (
        input  in_en, in_num, in_inst, dec_stall, flush,
        output full, out_en, out_inst
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and decode.
// Optional IBUFFER_BYPASS_EN forwards an incoming group straight to decode when empty.
`ifndef ICACHE_BANK
`define ICACHE_BANK 4
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int IN_W  = `ICACHE_BANK,
    parameter int OUT_W = `FETCH_WIDTH
) (
    input logic          clk,
    input logic          rst,
    inst_buffer_if.slave ib
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] mem_q [DEPTH];
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        count_q, count_d;
    cnt_t        free_w, avail_n, enq_n, deq_n, skip_n;
    logic        full_w, enq_w;
    logic        unused_en_w;

    function automatic cnt_t min_cnt(input cnt_t a, input cnt_t b);
        return (a < b) ? a : b;
    endfunction

    // Group size is carried by in_num; upper in_en bits are redundant with it.
    assign unused_en_w = ^ib.in_en[IN_W-1:1];

    assign free_w  = cnt_t'(DEPTH) - count_q;
    assign full_w  = free_w < cnt_t'(IN_W);
    assign ib.full = full_w;
    assign enq_w   = ib.in_en[0] && !full_w && !ib.flush;
    assign enq_n   = enq_w ? cnt_t'(ib.in_num) + cnt_t'(1) : '0;
    assign avail_n = min_cnt(count_q, cnt_t'(OUT_W));

    always_comb begin
        skip_n      = '0;
        deq_n       = (ib.dec_stall || ib.flush) ? '0 : avail_n;
        ib.out_en   = '0;
        ib.out_inst = '0;
        for (int i = 0; i < OUT_W; i++) begin
            ib.out_en[i]   = cnt_t'(i) < avail_n;
            ib.out_inst[i] = mem_q[head_q + ptr_t'(i)];
        end
`ifdef IBUFFER_BYPASS_EN
        // Empty buffer: the oldest incoming slots go to decode now, only the rest is stored.
        if (count_q == '0 && !ib.dec_stall && !ib.flush && ib.in_en[0]) begin
            skip_n = min_cnt(enq_n, cnt_t'(OUT_W));
            for (int i = 0; i < OUT_W; i++) begin
                ib.out_en[i]   = cnt_t'(i) < skip_n;
                ib.out_inst[i] = ib.in_inst[i % IN_W];
            end
        end
`endif
        if (ib.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + ptr_t'(deq_n);
            tail_d  = tail_q + ptr_t'(enq_n - skip_n);
            count_d = count_q + enq_n - skip_n - deq_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq_w) begin
            for (int k = 0; k < IN_W; k++) begin
                if (cnt_t'(k) >= skip_n && k <= int'(ib.in_num)) begin
                    mem_q[tail_q + ptr_t'(k) - ptr_t'(skip_n)] <= ib.in_inst[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer (DEPTH=16, 4-wide in and out, default build).
`timescale 1ns/1ps
module tb_inst_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inst_buffer_if #(.IN_W(4), .OUT_W(4)) ib ();

    inst_buffer #(.DEPTH(16), .IN_W(4), .OUT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .ib  (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       en;
        logic [1:0]       num;
        logic [3:0][31:0] inst;
        logic             stall;
        logic             fl;
        logic [3:0]       xen;
        logic [3:0][31:0] xi;
        logic             xfull;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [3:0][31:0] mk(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [3:0][31:0] seq(input logic [31:0] base);
        return mk(base, base + 32'd1, base + 32'd2, base + 32'd3);
    endfunction

    task automatic chk(input string nm, input logic [3:0] xen, input logic [3:0][31:0] xi,
                       input logic xfull);
        logic ok;
        checks++;
        if (ib.out_en !== xen) begin
            failures++;
            $display("FAIL %s out_en got=%b exp=%b", nm, ib.out_en, xen);
        end
        checks++;
        if (ib.full !== xfull) begin
            failures++;
            $display("FAIL %s full got=%b exp=%b", nm, ib.full, xfull);
        end
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (xen[i] && ib.out_inst[i] !== xi[i]) ok = 1'b0;
        if (xen != 4'b0000) begin
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s out_inst got=%h exp=%h en=%b", nm, ib.out_inst, xi, xen);
            end
        end
    endtask

    task automatic drive(input logic [3:0] en, input logic [1:0] num, input logic [31:0] base,
                         input logic stall, input logic fl);
        ib.in_en     = en;
        ib.in_num    = num;
        ib.in_inst   = seq(base);
        ib.dec_stall = stall;
        ib.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        ib.in_en     = '0;
        ib.in_num    = '0;
        ib.in_inst   = '0;
        ib.dec_stall = 1'b0;
        ib.flush     = 1'b0;

        tbl[0] = '{4'b1111, 2'd3, mk(32'h11, 32'h22, 32'h33, 32'h44), 1'b0, 1'b0,
                   4'b1111, mk(32'h11, 32'h22, 32'h33, 32'h44), 1'b0};
        tbl[1] = '{4'b0000, 2'd0, '0, 1'b0, 1'b0, 4'b0000, '0, 1'b0};
        tbl[2] = '{4'b0011, 2'd1, mk(32'hA1, 32'hA2, 0, 0), 1'b0, 1'b0,
                   4'b0011, mk(32'hA1, 32'hA2, 0, 0), 1'b0};
        tbl[3] = '{4'b0111, 2'd2, mk(32'hB1, 32'hB2, 32'hB3, 0), 1'b1, 1'b0,
                   4'b1111, mk(32'hA1, 32'hA2, 32'hB1, 32'hB2), 1'b0};
        tbl[4] = '{4'b0000, 2'd0, '0, 1'b0, 1'b0, 4'b0001, mk(32'hB3, 0, 0, 0), 1'b0};
        tbl[5] = '{4'b0000, 2'd0, '0, 1'b0, 1'b0, 4'b0000, '0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'b0000, '0, 1'b0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            ib.in_en     = tbl[v].en;
            ib.in_num    = tbl[v].num;
            ib.in_inst   = tbl[v].inst;
            ib.dec_stall = tbl[v].stall;
            ib.flush     = tbl[v].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", v), tbl[v].xen, tbl[v].xi, tbl[v].xfull);
        end

        // Fill under stall until full, then offer groups that must be ignored.
        drive(4'b1111, 2'd3, 32'h100, 1'b1, 1'b0); chk("fill4",  4'b1111, seq(32'h100), 1'b0);
        drive(4'b1111, 2'd3, 32'h110, 1'b1, 1'b0); chk("fill8",  4'b1111, seq(32'h100), 1'b0);
        drive(4'b1111, 2'd3, 32'h120, 1'b1, 1'b0); chk("fill12", 4'b1111, seq(32'h100), 1'b0);
        drive(4'b1111, 2'd3, 32'h130, 1'b1, 1'b0); chk("fill16", 4'b1111, seq(32'h100), 1'b1);
        drive(4'b1111, 2'd3, 32'hDEAD0, 1'b1, 1'b0); chk("full_hold1", 4'b1111, seq(32'h100), 1'b1);
        drive(4'b1111, 2'd3, 32'hBEEF0, 1'b1, 1'b0); chk("full_hold2", 4'b1111, seq(32'h100), 1'b1);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("drain12", 4'b1111, seq(32'h110), 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("drain8",  4'b1111, seq(32'h120), 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("drain4",  4'b1111, seq(32'h130), 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("drain0",  4'b0000, '0, 1'b0);

        // Bring head to 14, then enqueue across the wrap.
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b1); chk("flush_idle", 4'b0000, '0, 1'b0);
        drive(4'b1111, 2'd3, 32'h200, 1'b1, 1'b0); chk("w_fill1", 4'b1111, seq(32'h200), 1'b0);
        drive(4'b1111, 2'd3, 32'h210, 1'b1, 1'b0); chk("w_fill2", 4'b1111, seq(32'h200), 1'b0);
        drive(4'b1111, 2'd3, 32'h220, 1'b1, 1'b0); chk("w_fill3", 4'b1111, seq(32'h200), 1'b0);
        drive(4'b0011, 2'd1, 32'h230, 1'b1, 1'b0); chk("w_fill14", 4'b1111, seq(32'h200), 1'b1);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("w_drain1", 4'b1111, seq(32'h210), 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("w_drain2", 4'b1111, seq(32'h220), 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("w_drain3", 4'b0011, mk(32'h230, 32'h231, 0, 0), 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("w_head14", 4'b0000, '0, 1'b0);
        drive(4'b1111, 2'd3, 32'h300, 1'b1, 1'b0); chk("wrap_grp", 4'b1111, seq(32'h300), 1'b0);
        drive(4'b0111, 2'd2, 32'h310, 1'b0, 1'b0);
        chk("wrap_next", 4'b0111, mk(32'h310, 32'h311, 32'h312, 0), 1'b0);

        // Occupancy 8, then enqueue 3 while dequeuing 4.
        drive(4'b1111, 2'd3, 32'h320, 1'b1, 1'b0);
        chk("c7", 4'b1111, mk(32'h310, 32'h311, 32'h312, 32'h320), 1'b0);
        drive(4'b0001, 2'd0, 32'h330, 1'b1, 1'b0);
        chk("c8", 4'b1111, mk(32'h310, 32'h311, 32'h312, 32'h320), 1'b0);
        drive(4'b0111, 2'd2, 32'h340, 1'b0, 1'b0);
        chk("enq3_deq4", 4'b1111, mk(32'h321, 32'h322, 32'h323, 32'h330), 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0);
        chk("cnt7_rest", 4'b0111, mk(32'h340, 32'h341, 32'h342, 0), 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("cnt7_empty", 4'b0000, '0, 1'b0);

        // Occupancy 10, flush racing an enqueue.
        drive(4'b1111, 2'd3, 32'h400, 1'b1, 1'b0); chk("f_fill4", 4'b1111, seq(32'h400), 1'b0);
        drive(4'b1111, 2'd3, 32'h410, 1'b1, 1'b0); chk("f_fill8", 4'b1111, seq(32'h400), 1'b0);
        drive(4'b0011, 2'd1, 32'h420, 1'b1, 1'b0); chk("f_fill10", 4'b1111, seq(32'h400), 1'b0);
        drive(4'b1111, 2'd3, 32'h500, 1'b0, 1'b1); chk("flush_enq", 4'b0000, '0, 1'b0);
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("flush_dropped", 4'b0000, '0, 1'b0);
        drive(4'b0001, 2'd0, 32'h600, 1'b0, 1'b0); chk("post_flush", 4'b0001, mk(32'h600, 0, 0, 0), 1'b0);

        // Occupancy 6, then asynchronous reset between edges.
        drive(4'b1111, 2'd3, 32'h700, 1'b1, 1'b0);
        chk("r_fill5", 4'b1111, mk(32'h600, 32'h700, 32'h701, 32'h702), 1'b0);
        drive(4'b0001, 2'd0, 32'h710, 1'b1, 1'b0);
        chk("r_fill6", 4'b1111, mk(32'h600, 32'h700, 32'h701, 32'h702), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 4'b0000, '0, 1'b0);
        #1;
        rst = 1'b0;
        drive(4'b0000, 2'd0, 32'h0, 1'b0, 1'b0); chk("after_rst", 4'b0000, '0, 1'b0);
        drive(4'b1111, 2'd3, 32'h800, 1'b0, 1'b0); chk("rst_resume", 4'b1111, seq(32'h800), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
